// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with programmable period, edge- or
// center-aligned counting and per-channel duty values written through a
// shared port. Duty, period and mode changes are double-buffered and only
// reach the waveform at a period boundary, so no output ever glitches.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [WIDTH-1:0]    period,
    input  logic                mode,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [WIDTH-1:0]    cnt_r;
    logic                dir_r;
    logic [WIDTH-1:0]    active_period_r;
    logic                active_mode_r;
    logic [WIDTH-1:0]    shadow_duty_r [CHANNELS];
    logic [WIDTH-1:0]    active_duty_r [CHANNELS];
    logic [CHANNELS-1:0] pwm_out_r;
    logic                period_start_r;

    logic                running_s;
    logic                last_s;
    logic                load_s;
    logic [WIDTH-1:0]    cnt_next_s;
    logic                dir_next_s;
    logic [CHANNELS-1:0] pwm_next_s;
    logic                start_next_s;
    logic [WIDTH-1:0]    shadow_next_s [CHANNELS];

    // Run/idle status, end-of-period detection and active-set load strobe.
    always_comb begin
        running_s = en && (active_period_r != '0);
        if (active_mode_r) begin
            last_s = (dir_r == DIR_DOWN) && (cnt_r == '0);
        end else begin
            last_s = (cnt_r == active_period_r);
        end
        load_s = !running_s || last_s;
    end

    // Shadow duty update; a same-cycle write is visible to the active load.
    // Writes to a channel index that does not exist match no channel.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (wr_en && (int'(wr_ch) == ch)) begin
                shadow_next_s[ch] = wr_duty;
            end else begin
                shadow_next_s[ch] = shadow_duty_r[ch];
            end
        end
    end

    // Counter sequencing: edge mode wraps P->0, center mode holds the turn
    // value for one extra cycle at each end of the triangle.
    always_comb begin
        cnt_next_s = '0;
        dir_next_s = DIR_UP;
        if (!running_s || last_s) begin
            cnt_next_s = '0;
            dir_next_s = DIR_UP;
        end else if (!active_mode_r) begin
            cnt_next_s = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
            dir_next_s = DIR_UP;
        end else if (dir_r == DIR_UP) begin
            if (cnt_r == active_period_r - {{(WIDTH-1){1'b0}}, 1'b1}) begin
                cnt_next_s = cnt_r;
                dir_next_s = DIR_DOWN;
            end else begin
                cnt_next_s = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
                dir_next_s = DIR_UP;
            end
        end else begin
            cnt_next_s = cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
            dir_next_s = DIR_DOWN;
        end
    end

    // Per-channel compare and period-start detection for the output stage.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            pwm_next_s[ch] = running_s && (cnt_r < active_duty_r[ch]);
        end
        start_next_s = running_s && (cnt_r == '0) && (dir_r == DIR_UP);
    end

    // State registers: counter, buffered settings and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r           <= '0;
            dir_r           <= DIR_UP;
            active_period_r <= '0;
            active_mode_r   <= 1'b0;
            pwm_out_r       <= '0;
            period_start_r  <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                shadow_duty_r[ch] <= '0;
                active_duty_r[ch] <= '0;
            end
        end else begin
            cnt_r          <= cnt_next_s;
            dir_r          <= dir_next_s;
            pwm_out_r      <= pwm_next_s;
            period_start_r <= start_next_s;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                shadow_duty_r[ch] <= shadow_next_s[ch];
            end
            if (load_s) begin
                active_period_r <= period;
                active_mode_r   <= mode;
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    active_duty_r[ch] <= shadow_next_s[ch];
                end
            end else begin
                active_period_r <= active_period_r;
                active_mode_r   <= active_mode_r;
            end
        end
    end

    assign pwm_out      = pwm_out_r;
    assign period_start = period_start_r;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator. Successor to the single-channel 8-bit free-running PWM.
- Adds the following:
  - programmable period;
  - per-channel duty written through a shared write port;
  - edge-aligned or center-aligned counting;
  - glitch-free double-buffered updates that take effect only at a period boundary.
- Sits between the SPI register decode and the FPGA output pins. Runs in the PWM clock domain.

Parameters:
- WIDTH, 8: bit width of the counter, period and duty values.
- CHANNELS, 4: number of PWM outputs. Legal range 1..16.
- CH_W, $clog2(CHANNELS) (minimum 1): width of the channel select.

Ports:
- clk  in  1  PWM clock. All logic is on the rising edge.
- rst_n  in  1  Synchronous reset, active-low.
- en  in  1  Global enable.
- period  in  WIDTH  Period value P. Sampled only at load points.
- mode  in  1  0 = edge-aligned, 1 = center-aligned. Sampled only at load points.
- wr_en  in  1  Duty write strobe, one cycle.
- wr_ch  in  CH_W  Channel index for the write.
- wr_duty  in  WIDTH  Duty value D for the write.
- pwm_out  out  CHANNELS  Registered PWM outputs.
- period_start  out  1  One-cycle pulse, aligned with the first output cycle of each period.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state:
  - pwm_out=0, period_start=0, counter=0, direction=up;
  - all shadow duties=0, all active duties=0, active period=0, active mode=0.
- Registers:
  - shadow_duty[ch]: written when wr_en=1 and wr_ch<CHANNELS. Writes with wr_ch>=CHANNELS are ignored.
  - Active set: active_duty[], active_period, active_mode.
- Load points: the active set is loaded from shadow_duty[], period and mode:
  - every cycle while the counter is idle (en=0 or active_period=0);
  - on the last cycle of each running period.
  - A write in the same cycle as a load point is bypassed into the active load, so the new value wins.
- Edge mode (active_mode=0):
  - Counter runs 0,1,..,P then wraps to 0. Period is P+1 cycles.
  - Last cycle of the period is cnt==P.
- Center mode (active_mode=1):
  - Counter runs up 0..P-1, then down P-1..0, so each value appears twice. Period is 2P cycles.
  - Direction flips after the up-phase cnt==P-1 (that value is repeated).
  - Last cycle of the period is the down-phase cnt==0.
- Compare: next pwm_out[ch] = (cnt < active_duty[ch]), with WIDTH-bit unsigned compare.
  - Edge mode: high time = min(D, P+1) cycles. D >= P+1 gives constant high.
  - Center mode: high time = 2*min(D, P) cycles, symmetric about the period midpoint.
  - D=0 gives constant low in both modes.
- Latency: pwm_out and period_start are registered, one cycle after the counter value that produced them.
- period_start: next value is 1 when the counter is running and cnt==0 at the start of a period (up phase in center mode). Otherwise 0.
- Idle (en=0 or active_period=0):
  - counter held at 0 with direction=up;
  - pwm_out=0 from the next cycle; period_start=0.
  - Shadow writes are still accepted.
- en deassert mid-period: stop immediately. pwm_out goes low the following cycle and the counter is held at 0.
- en reassert: first running cycle has cnt=0 using the freshly loaded active set. period_start pulses one cycle later.
- Period, duty or mode changes mid-period never alter the current period's waveform.
- Reset mid-operation overrides en and writes in that cycle.
- Wrap-around: P=2^WIDTH-1 is legal.
  - Edge mode: counter wraps naturally.
  - Center mode: P=1 gives the sequence 0,0, period 2.

Test Plan:
- Edge mode, P=9, ch0 D=3, ch1 D=0, ch2 D=10, ch3 D=255 -> period 10 cycles:
  - ch0 high 3 / low 7;
  - ch1 constant 0;
  - ch2 and ch3 constant 1;
  - period_start pulses every 10 cycles.
- Center mode, P=4, ch0 D=2 -> 8-cycle period with pattern 1,1,0,0,0,0,1,1, i.e. high 4 cycles centered on the period edges and low in the middle.
- Mid-period write, edge P=9, ch0 D=3 -> write D=7 at cnt=5:
  - current period keeps 3 high cycles;
  - next period shows 7 high cycles;
  - a write at cnt=9 also applies to the next period.
- Period/mode change mid-period: P 9->4 and mode 0->1 at cnt=2 -> current 10-cycle period completes, then 8-cycle center periods follow.
- Enable/idle:
  - en=0 at cnt=4 -> pwm_out=0 next cycle and the counter is held;
  - en=1 -> period_start 1 cycle after the first cnt=0;
  - P=0 with en=1 -> outputs stay 0.
- Reset and range checks:
  - rst_n=0 mid-period (D=5, P=9) -> all outputs 0 next cycle and shadows cleared;
  - wr_ch=CHANNELS with CHANNELS=3 -> write ignored, no channel changes.
